msu_multi: RTL
==============

# msu_multi

Parametrised multi-channel successor to the single-channel MSU register block. It decodes the SNES-side MSU register window and exposes NUM_CH independent audio channels, each with its own track, volume, control and status. It adds a double-buffered data port whose read pointer wraps across two buffer halves and raises refill requests to the MCU. It sits between the SNES bus decoder (single-cycle oe/we strobes) and the MCU status/command interface; the data buffer RAM is external.

## Interface
- NUM_CH, 2, audio channel count (1..4)
- BUF_AW, 14, data buffer address width; halves selected by bit BUF_AW-1
- clkin  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  register window selected
- reg_addr  in  4  register index
- reg_data_in  in  8  SNES write data
- reg_data_out  out  8  SNES read data
- reg_oe_falling, reg_oe_rising, reg_we_rising  in  1 each  single-cycle bus strobes
- buf_addr  out  BUF_AW  data buffer read address
- buf_data  in  8  buffer read data, valid 1 cycle after buf_addr
- addr_out  out  32  seek address; data_start  out  1  seek request
- track_out  out  16*NUM_CH; volume_out  out  8*NUM_CH; volume_latch_out  out  NUM_CH; audio_start_out  out  NUM_CH; ctrl_out  out  3*NUM_CH  (channel n at slice n)
- refill_req  out  2  per-half refill pending
- status_ch  in  2  channel addressed by the MCU status write
- status_set_bits, status_reset_bits  in  6 each  MCU status set/clear masks
- status_we  in  1  MCU status strobe (async level, rising edge acts)
- buf_addr_ext  in  BUF_AW; buf_addr_ext_write  in  1  MCU pointer load (async level, rising edge acts)
- half_fill_done  in  2  MCU half-filled strobes (async levels, rising edge acts)

## Operation
- Reset: reg_data_out 0, buf_addr 0, addr_out 0, data_start 0, refill_req 2'b00, half_valid 2'b00, data_busy 1; per channel: track 0, volume 0, volume_latch 0, audio_start 0, ctrl 0, audio_busy 1, audio_error 0, audio_status 0, ctrl_start 0; chan_sel 0.
- Writes (reg_we_rising & enable): 0..2 addr_out bytes 0..2; 3 addr_out[31:24], data_start=1, data_busy=1, half_valid=0; 4 chan_sel = data[1:0] (values >= NUM_CH ignored); 5 track[chan_sel][7:0]; 6 track[chan_sel][15:8], audio_start=1, audio_busy=1; 7 volume[chan_sel], volume_latch pulse 1 cycle; 8 ctrl[chan_sel]=data[2:0], ctrl_start=1, only if that channel is not audio_busy; 9..15 ignored.
- Reads, latched on reg_oe_falling & enable: 0 {data_busy | ~half_valid[buf_addr[BUF_AW-1]], audio_busy, audio_status[1:0], audio_error, 3'b001} of chan_sel; 1 buf_data; 2..7 "S-MSU1" (53 2D 4D 53 55 31); 8 {6'b0, chan_sel}; 9..15 0x00.
- Data port: reg_oe_rising & enable & addr 1 increments buf_addr mod 2^BUF_AW. When the increment changes bit BUF_AW-1, the half just left gets half_valid=0 and refill_req=1.
- half_fill_done[h] edge: half_valid[h]=1, refill_req[h]=0.
- buf_addr_ext_write edge: buf_addr=buf_addr_ext; this takes priority over a same-cycle increment and raises no refill.
- Status strobe edge, applied to channel status_ch (ignored if >= NUM_CH): bit5 audio_busy (clear also drops audio_start); bit4 data_busy (clear also drops data_start); bit3 audio_error; bits2:1 audio_status; bit0 ctrl_start. New value = (old | set) & ~reset.
- Simultaneous SNES write and status strobe: both apply. Where they touch the same flag, the SNES write wins.

## Timing
- MCU async inputs: 2-FF sync plus edge detect, so they act 3 clkin cycles after the input rises.
- Read data registered 1 cycle after reg_oe_falling. buf_addr must be stable at least 2 cycles before the next oe_falling, which bus timing guarantees.
- Outputs change 1 cycle after their strobe; volume_latch_out is high exactly 1 cycle.
- rst_n assertion mid-operation clears everything immediately. Strobe synchronisers also reset, so no spurious edge after release.

## Test plan
- Reset, then read regs 2..7 -> 53 2D 4D 53 55 31; reg 0 -> 0xC1 (busy bits set, half invalid).
- chan_sel=1, write 0x34 to reg 5, 0x12 to reg 6 -> track_out[31:16]=0x1234, audio_start_out=2'b10, channel 0 untouched. MCU status reset 0x20 on ch1 -> audio_start cleared after 3 cycles.
- ext pointer load 0x1FFE, half_fill_done both; three reads of reg 1 -> buf_addr 0x2001, refill_req=2'b01. fill_done[0] -> refill_req=0.
- Pointer 0x3FFF, one read -> wraps to 0x0000, refill_req[1]=1, reg0 bit7 = ~half_valid[0].
- Write reg 8 while audio_busy=1 -> ctrl unchanged; clear busy, rewrite 0x05 -> ctrl_out=5, ctrl_start=1.
- Same-cycle SNES write reg 6 and MCU reset bit5 on same channel -> audio_busy=1; rst_n pulse mid-sequence -> all outputs at reset values.

Source files
------------

// File: rtl/msu_multi.sv
// msu_multi: multi-channel MSU register block with a double-buffered data port.
// Decodes the SNES register window and merges synchronised MCU status/pointer strobes.
module msu_multi #(
  parameter int NUM_CH = 2,
  parameter int BUF_AW = 14
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [3:0]             reg_addr,
  input  logic [7:0]             reg_data_in,
  output logic [7:0]             reg_data_out,
  input  logic                   reg_oe_falling,
  input  logic                   reg_oe_rising,
  input  logic                   reg_we_rising,
  output logic [BUF_AW-1:0]      buf_addr,
  input  logic [7:0]             buf_data,
  output logic [31:0]            addr_out,
  output logic                   data_start,
  output logic [16*NUM_CH-1:0]   track_out,
  output logic [8*NUM_CH-1:0]    volume_out,
  output logic [NUM_CH-1:0]      volume_latch_out,
  output logic [NUM_CH-1:0]      audio_start_out,
  output logic [3*NUM_CH-1:0]    ctrl_out,
  output logic [1:0]             refill_req,
  input  logic [1:0]             status_ch,
  input  logic [5:0]             status_set_bits,
  input  logic [5:0]             status_reset_bits,
  input  logic                   status_we,
  input  logic [BUF_AW-1:0]      buf_addr_ext,
  input  logic                   buf_addr_ext_write,
  input  logic [1:0]             half_fill_done
);

  localparam int Msb = BUF_AW - 1;
  localparam logic [BUF_AW-1:0] AddrOne = BUF_AW'(1);

  logic [3:0] asyncIn;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] edges;
  logic       statusEdge, extEdge;
  logic [1:0] fillEdge;
  logic       weHit, oeFallHit, oeRiseHit;

  logic [7:0]        regData_q, regData_d;
  logic [BUF_AW-1:0] bufAddr_q, bufAddr_d;
  logic [31:0]       addr_q, addr_d;
  logic              dataStart_q, dataStart_d;
  logic              dataBusy_q, dataBusy_d;
  logic [1:0]        halfValid_q, halfValid_d;
  logic [1:0]        refill_q, refill_d;
  logic [1:0]        chanSel_q, chanSel_d;

  logic [15:0]       track_q [NUM_CH];
  logic [15:0]       track_d [NUM_CH];
  logic [7:0]        volume_q [NUM_CH];
  logic [7:0]        volume_d [NUM_CH];
  logic [2:0]        ctrl_q [NUM_CH];
  logic [2:0]        ctrl_d [NUM_CH];
  logic [1:0]        audioStatus_q [NUM_CH];
  logic [1:0]        audioStatus_d [NUM_CH];
  logic [NUM_CH-1:0] volLatch_q, volLatch_d;
  logic [NUM_CH-1:0] audioStart_q, audioStart_d;
  logic [NUM_CH-1:0] audioBusy_q, audioBusy_d;
  logic [NUM_CH-1:0] audioError_q, audioError_d;
  logic [NUM_CH-1:0] ctrlStart_q, ctrlStart_d;

  logic [7:0] selStatus;

  // MCU strobes are asynchronous levels: two flops to resynchronise, a third for the edge.
  assign asyncIn = {half_fill_done, buf_addr_ext_write, status_we};

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= asyncIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edges      = sync2_q & ~prev_q;
  assign statusEdge = edges[0];
  assign extEdge    = edges[1];
  assign fillEdge   = edges[3:2];
  assign weHit      = reg_we_rising & enable;
  assign oeFallHit  = reg_oe_falling & enable;
  assign oeRiseHit  = reg_oe_rising & enable;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      regData_q    <= '0;
      bufAddr_q    <= '0;
      addr_q       <= '0;
      dataStart_q  <= 1'b0;
      dataBusy_q   <= 1'b1;
      halfValid_q  <= '0;
      refill_q     <= '0;
      chanSel_q    <= '0;
      volLatch_q   <= '0;
      audioStart_q <= '0;
      audioBusy_q  <= '1;
      audioError_q <= '0;
      ctrlStart_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        track_q[c]       <= '0;
        volume_q[c]      <= '0;
        ctrl_q[c]        <= '0;
        audioStatus_q[c] <= '0;
      end
    end else begin
      regData_q     <= regData_d;
      bufAddr_q     <= bufAddr_d;
      addr_q        <= addr_d;
      dataStart_q   <= dataStart_d;
      dataBusy_q    <= dataBusy_d;
      halfValid_q   <= halfValid_d;
      refill_q      <= refill_d;
      chanSel_q     <= chanSel_d;
      volLatch_q    <= volLatch_d;
      audioStart_q  <= audioStart_d;
      audioBusy_q   <= audioBusy_d;
      audioError_q  <= audioError_d;
      ctrlStart_q   <= ctrlStart_d;
      track_q       <= track_d;
      volume_q      <= volume_d;
      ctrl_q        <= ctrl_d;
      audioStatus_q <= audioStatus_d;
    end
  end

  // MCU status is applied first so a same-cycle SNES write overrides any shared flag.
  always_comb begin
    bufAddr_d     = bufAddr_q;
    addr_d        = addr_q;
    dataStart_d   = dataStart_q;
    dataBusy_d    = dataBusy_q;
    halfValid_d   = halfValid_q;
    refill_d      = refill_q;
    chanSel_d     = chanSel_q;
    volLatch_d    = '0;
    audioStart_d  = audioStart_q;
    audioBusy_d   = audioBusy_q;
    audioError_d  = audioError_q;
    ctrlStart_d   = ctrlStart_q;
    track_d       = track_q;
    volume_d      = volume_q;
    ctrl_d        = ctrl_q;
    audioStatus_d = audioStatus_q;

    if (statusEdge) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (status_ch == c[1:0]) begin
          audioBusy_d[c]   = (audioBusy_q[c] | status_set_bits[5]) & ~status_reset_bits[5];
          if (status_reset_bits[5]) audioStart_d[c] = 1'b0;
          dataBusy_d       = (dataBusy_q | status_set_bits[4]) & ~status_reset_bits[4];
          if (status_reset_bits[4]) dataStart_d = 1'b0;
          audioError_d[c]  = (audioError_q[c] | status_set_bits[3]) & ~status_reset_bits[3];
          audioStatus_d[c] = (audioStatus_q[c] | status_set_bits[2:1]) & ~status_reset_bits[2:1];
          ctrlStart_d[c]   = (ctrlStart_q[c] | status_set_bits[0]) & ~status_reset_bits[0];
        end
      end
    end

    for (int h = 0; h < 2; h++) begin
      if (fillEdge[h]) begin
        halfValid_d[h] = 1'b1;
        refill_d[h]    = 1'b0;
      end
    end

    // Leaving a half invalidates it and asks the MCU to refill it.
    if (extEdge) begin
      bufAddr_d = buf_addr_ext;
    end else if (oeRiseHit && reg_addr == 4'd1) begin
      bufAddr_d = bufAddr_q + AddrOne;
      if (bufAddr_d[Msb] != bufAddr_q[Msb]) begin
        halfValid_d[bufAddr_q[Msb]] = 1'b0;
        refill_d[bufAddr_q[Msb]]    = 1'b1;
      end
    end

    if (weHit) begin
      case (reg_addr)
        4'd0: addr_d[7:0]   = reg_data_in;
        4'd1: addr_d[15:8]  = reg_data_in;
        4'd2: addr_d[23:16] = reg_data_in;
        4'd3: begin
          addr_d[31:24] = reg_data_in;
          dataStart_d   = 1'b1;
          dataBusy_d    = 1'b1;
          halfValid_d   = '0;
        end
        4'd4: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (reg_data_in[1:0] == c[1:0]) chanSel_d = reg_data_in[1:0];
          end
        end
        4'd5, 4'd6, 4'd7, 4'd8: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (chanSel_q == c[1:0]) begin
              case (reg_addr)
                4'd5: track_d[c][7:0] = reg_data_in;
                4'd6: begin
                  track_d[c][15:8] = reg_data_in;
                  audioStart_d[c]  = 1'b1;
                  audioBusy_d[c]   = 1'b1;
                end
                4'd7: begin
                  volume_d[c]   = reg_data_in;
                  volLatch_d[c] = 1'b1;
                end
                default: begin
                  if (!audioBusy_q[c]) begin
                    ctrl_d[c]      = reg_data_in[2:0];
                    ctrlStart_d[c] = 1'b1;
                  end
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is captured on the falling oe strobe and held until the next read.
  always_comb begin
    selStatus = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chanSel_q == c[1:0]) begin
        selStatus = {dataBusy_q | ~halfValid_q[bufAddr_q[Msb]], audioBusy_q[c],
                     audioStatus_q[c], audioError_q[c], 3'b001};
      end
    end

    regData_d = regData_q;
    if (oeFallHit) begin
      case (reg_addr)
        4'd0:    regData_d = selStatus;
        4'd1:    regData_d = buf_data;
        4'd2:    regData_d = 8'h53;
        4'd3:    regData_d = 8'h2D;
        4'd4:    regData_d = 8'h4D;
        4'd5:    regData_d = 8'h53;
        4'd6:    regData_d = 8'h55;
        4'd7:    regData_d = 8'h31;
        4'd8:    regData_d = {6'b0, chanSel_q};
        default: regData_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    track_out  = '0;
    volume_out = '0;
    ctrl_out   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      track_out[16*c +: 16] = track_q[c];
      volume_out[8*c +: 8]  = volume_q[c];
      ctrl_out[3*c +: 3]    = ctrl_q[c];
    end
  end

  assign reg_data_out     = regData_q;
  assign buf_addr         = bufAddr_q;
  assign addr_out         = addr_q;
  assign data_start       = dataStart_q;
  assign volume_latch_out = volLatch_q;
  assign audio_start_out  = audioStart_q;
  assign refill_req       = refill_q;

endmodule
